// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: RV32IC instruction fetch responder with a one-word
// line buffer and straddle assembly over a 1-cycle synchronous memory.
//
// Ports:
//   clk, reset (async, active-low)
//   req_i, pc_i, flush_i       core fetch request / redirect
//   fencei_i                   buffer invalidate (only with FETCH_FENCEI_EN)
//   instr_o, instr_vld_o,      returned instruction (compressed is
//   is_c_o, stall_o            zero-extended), valid, 16-bit flag, stall
//   mem_rd_o, mem_addr_o,      memory read strobe, word address and
//   mem_rdata_i                read data (valid one cycle after strobe)
//
// Macro FETCH_FENCEI_EN adds fencei_i; undefined, the buffer is only
// invalidated by reset.

module imem_fetch_resp #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic [31:0]       pc_i,
   input  logic              flush_i,
`ifdef FETCH_FENCEI_EN
   input  logic              fencei_i,
`endif
   output logic [31:0]       instr_o,
   output logic              instr_vld_o,
   output logic              is_c_o,
   output logic              stall_o,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LO = 2'd1,
      WAIT_HI = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         buf_word_q;
   logic [ADDR_W-1:0]   buf_tag_q;
   logic                buf_vld_q;
   logic [15:0]         spill_q;
   // word address of the outstanding fill, latched at issue so the
   // buffer tag stays correct even if the core drops its request
   logic [ADDR_W-1:0]   fill_tag_q, fill_tag_d;

   logic [ADDR_W-1:0]   w, w1;
   logic                hit, comp, hit_resp, kill, inval;
   logic [15:0]         half;

`ifdef FETCH_FENCEI_EN
   assign inval = fencei_i;
`else
   assign inval = 1'b0;
`endif

   // a fence.i abandons an in-flight fill exactly like a redirect
   assign kill = flush_i | inval;

   assign w    = pc_i[ADDR_W+1:2];
   assign w1   = w + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign hit  = buf_vld_q & (buf_tag_q == w);
   assign half = pc_i[1] ? buf_word_q[31:16] : buf_word_q[15:0];
   assign comp = half[1:0] != 2'b11;

   // whole instruction available from the buffer this cycle
   assign hit_resp = hit & (~pc_i[1] | comp);

   logic unused_pc;
   assign unused_pc = ^{pc_i[31:ADDR_W+2], pc_i[0]};

   // Outputs are combinational so buffer hits cost no stall; reset
   // forces them low immediately.
   always_comb begin
      instr_o     = 32'h0;
      instr_vld_o = 1'b0;
      is_c_o      = 1'b0;
      mem_rd_o    = 1'b0;
      mem_addr_o  = '0;
      state_d     = state_q;
      fill_tag_d  = fill_tag_q;
      if (reset) begin
         unique case (state_q)
            IDLE: begin
               if (req_i && !kill) begin
                  if (hit_resp) begin
                     instr_vld_o = 1'b1;
                     is_c_o      = comp;
                     instr_o     = comp ? {16'h0, half} : buf_word_q;
                  end else if (hit) begin
                     mem_rd_o   = 1'b1;
                     mem_addr_o = w1;
                     fill_tag_d = w1;
                     state_d    = WAIT_HI;
                  end else begin
                     mem_rd_o   = 1'b1;
                     mem_addr_o = w;
                     fill_tag_d = w;
                     state_d    = WAIT_LO;
                  end
               end
            end
            WAIT_LO: begin
               state_d = IDLE;
            end
            WAIT_HI: begin
               state_d = IDLE;
               if (req_i && !kill) begin
                  instr_vld_o = 1'b1;
                  instr_o     = {mem_rdata_i[15:0], spill_q};
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign stall_o = req_i & ~instr_vld_o;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         buf_word_q <= 32'h0;
         buf_tag_q  <= '0;
         buf_vld_q  <= 1'b0;
         spill_q    <= 16'h0;
         fill_tag_q <= '0;
      end else begin
         state_q    <= state_d;
         fill_tag_q <= fill_tag_d;
         if (state_q == IDLE && req_i && !kill && hit && !hit_resp) begin
            spill_q <= buf_word_q[31:16];
         end
         if (!kill && (state_q == WAIT_LO || state_q == WAIT_HI)) begin
            buf_word_q <= mem_rdata_i;
            buf_tag_q  <= fill_tag_q;
            buf_vld_q  <= 1'b1;
         end
         if (inval) begin
            buf_vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// tb_imem_fetch_resp: vector table plus scoreboard for imem_fetch_resp,
// with hand sequences for flush, request drop, reset and address wrap.

module tb_imem_fetch_resp;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req, flush;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        vld, is_c, stall, mem_rd;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata;

   logic        req4;
   logic [31:0] pc4;
   logic [31:0] instr4;
   logic        vld4, is_c4, stall4, mem_rd4;
   logic [3:0]  mem_addr4;
   logic [31:0] mem_rdata4;

   logic [31:0] mem  [0:15];
   logic [31:0] mem4 [0:15];

   imem_fetch_resp #(.ADDR_W(16)) dut (
      .clk(clk), .reset(reset), .req_i(req), .pc_i(pc),
      .flush_i(flush),
`ifdef FETCH_FENCEI_EN
      .fencei_i(1'b0),
`endif
      .instr_o(instr), .instr_vld_o(vld), .is_c_o(is_c),
      .stall_o(stall), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
      .mem_rdata_i(mem_rdata)
   );

   imem_fetch_resp #(.ADDR_W(4)) dut4 (
      .clk(clk), .reset(reset), .req_i(req4), .pc_i(pc4),
      .flush_i(1'b0),
`ifdef FETCH_FENCEI_EN
      .fencei_i(1'b0),
`endif
      .instr_o(instr4), .instr_vld_o(vld4), .is_c_o(is_c4),
      .stall_o(stall4), .mem_rd_o(mem_rd4), .mem_addr_o(mem_addr4),
      .mem_rdata_i(mem_rdata4)
   );

   always @(posedge clk) begin
      if (mem_rd)
         mem_rdata <= (mem_addr < 16) ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
      if (mem_rd4)
         mem_rdata4 <= mem4[mem_addr4];
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        c;
      int          stalls;
      int          rds;
      logic [15:0] addr0;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic        c;
      int          stalls;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[11];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic pop_cmp(input logic [31:0] ai, input logic ac,
                          input int ast);
      exp_t e;
      if (sbq.size() == 0) begin
         chk("unexpected_vld", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk("instr", ai, e.instr);
         chk("is_c", {31'h0, ac}, {31'h0, e.c});
         chk("stalls", ast, e.stalls);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc, nrd;
      logic [15:0] a0;
      bit          done;
      sbq.push_back('{v.instr, v.c, v.stalls});
      req = 1'b1;
      pc  = v.pc;
      cyc = 0;
      nrd = 0;
      a0  = '0;
      done = 0;
      while (!done && cyc < 10) begin
         @(negedge clk);
         if (mem_rd) begin
            if (nrd == 0) a0 = mem_addr;
            nrd++;
         end
         chk("stall", {31'h0, stall}, (cyc == v.stalls) ? 32'd0 : 32'd1);
         if (vld) begin
            pop_cmp(instr, is_c, cyc);
            done = 1;
         end else begin
            cyc++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         chk("timeout", 32'd1, 32'd0);
         void'(sbq.pop_front());
      end
      req = 1'b0;
      chk("reads", nrd, v.rds);
      if (v.rds > 0) chk("addr0", {16'h0, a0}, {16'h0, v.addr0});
   endtask

   initial begin
      int          cyc, nrd;
      logic [3:0]  a_first, a_last;
      bit          done;

      vecs[0]  = '{32'h0, 32'h00A0_0093, 1'b0, 2, 1, 16'd0};
      vecs[1]  = '{32'h4, 32'h0000_0001, 1'b1, 2, 1, 16'd1};
      vecs[2]  = '{32'h6, 32'h0010_0513, 1'b0, 1, 1, 16'd2};
      vecs[3]  = '{32'hA, 32'h0000_4501, 1'b1, 0, 0, 16'd0};
      vecs[4]  = '{32'h8, 32'h0000_0010, 1'b1, 0, 0, 16'd0};
      vecs[5]  = '{32'h8, 32'h0000_0010, 1'b1, 0, 0, 16'd0};
      vecs[6]  = '{32'h0, 32'h00A0_0093, 1'b0, 2, 1, 16'd0};
      vecs[7]  = '{32'h2, 32'h0000_00A0, 1'b1, 0, 0, 16'd0};
      vecs[8]  = '{32'h6, 32'h0010_0513, 1'b0, 3, 2, 16'd1};
      vecs[9]  = '{32'h4, 32'h0000_0001, 1'b1, 0, 0, 16'd0};
      vecs[10] = '{32'h6, 32'h0010_0513, 1'b0, 3, 2, 16'd1};

      for (int i = 0; i < 16; i++) begin
         mem[i]  = 32'h0;
         mem4[i] = 32'h0;
      end
      mem[0]   = 32'h00A0_0093;
      mem[1]   = 32'h0513_0001;
      mem[2]   = 32'h4501_0010;
      mem4[15] = 32'h0513_0000;
      mem4[0]  = 32'h4501_0010;

      reset = 1'b0;
      req   = 1'b1;
      pc    = 32'h0;
      flush = 1'b0;
      req4  = 1'b0;
      pc4   = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_vld", {31'h0, vld}, 32'd0);
      chk("rst_rd", {31'h0, mem_rd}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_is_c", {31'h0, is_c}, 32'd0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req   = 1'b0;

      for (int i = 0; i <= 4; i++) run_vec(vecs[i]);

      // redirect during a miss: fill must be discarded
      req = 1'b1;
      pc  = 32'h100;
      @(negedge clk);
      chk("fl_rd", {31'h0, mem_rd}, 32'd1);
      chk("fl_addr", {16'h0, mem_addr}, 32'h40);
      @(posedge clk);
      #1;
      flush = 1'b1;
      pc    = 32'h0;
      @(negedge clk);
      chk("fl_vld", {31'h0, vld}, 32'd0);
      chk("fl_rd2", {31'h0, mem_rd}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      req   = 1'b0;

      for (int i = 5; i <= 8; i++) run_vec(vecs[i]);

      // request dropped while a fill is in flight
      req = 1'b1;
      pc  = 32'h4;
      @(negedge clk);
      chk("drop_rd", {31'h0, mem_rd}, 32'd1);
      chk("drop_addr", {16'h0, mem_addr}, 32'h1);
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      chk("drop_vld", {31'h0, vld}, 32'd0);
      @(posedge clk);
      #1;
      run_vec(vecs[9]);

      // reset asserted in the middle of a straddle fill
      req = 1'b1;
      pc  = 32'h6;
      @(negedge clk);
      chk("rhi_addr", {16'h0, mem_addr}, 32'h2);
      @(posedge clk);
      #1;
      chk("rhi_vld_pre", {31'h0, vld}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rhi_vld", {31'h0, vld}, 32'd0);
      chk("rhi_instr", instr, 32'h0);
      chk("rhi_rd", {31'h0, mem_rd}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_vec(vecs[10]);

      // word-address wrap with a 4-bit memory port
      sbq.push_back('{32'h0010_0513, 1'b0, 3});
      req4 = 1'b1;
      pc4  = 32'h3E;
      cyc = 0;
      nrd = 0;
      a_first = '0;
      a_last  = 4'hF;
      done = 0;
      while (!done && cyc < 10) begin
         @(negedge clk);
         if (mem_rd4) begin
            if (nrd == 0) a_first = mem_addr4;
            a_last = mem_addr4;
            nrd++;
         end
         if (vld4) begin
            pop_cmp(instr4, is_c4, cyc);
            done = 1;
         end else begin
            cyc++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         chk("w4_timeout", 32'd1, 32'd0);
         void'(sbq.pop_front());
      end
      req4 = 1'b0;
      chk("w4_reads", nrd, 32'd2);
      chk("w4_addr_first", {28'h0, a_first}, 32'hF);
      chk("w4_addr_last", {28'h0, a_last}, 32'h0);

      chk("sb_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
- Instruction-side responder for the RV32IC core fetch port.
- The core presents a halfword-aligned PC and a request; this block returns a complete 16- or 32-bit instruction, or holds the core with stall.
- Reads a single-port, synchronous-read, 32-bit-wide instruction memory, one cycle of read latency.
- Holds a one-word line buffer so sequential and compressed fetches avoid re-reads. Assembles 32-bit instructions that straddle a word boundary from two memory reads.

Parameters:
- ADDR_W, 16, word-address width of the memory port; word address = pc_i[ADDR_W+1:2].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_i  in  1  fetch request; pc_i is valid
- pc_i  in  32  fetch PC; bit 0 ignored
- flush_i  in  1  redirect (mispredict/branch); abandons the in-flight fetch
- instr_o  in the out direction  32  instruction; compressed = {16'h0, half}
- instr_vld_o  out  1  instr_o valid this cycle
- is_c_o  out  1  instr_o is a 16-bit instruction
- stall_o  out  1  req_i & ~instr_vld_o; core holds pc_i while high
- mem_rd_o  out  1  memory read strobe
- mem_addr_o  out  ADDR_W  memory word address
- mem_rdata_i  in  32  read data, valid the cycle after mem_rd_o

Behaviour:
- State: FSM {IDLE, WAIT_LO, WAIT_HI}; buf_word[31:0], buf_tag[ADDR_W-1:0], buf_vld, spill[15:0].
- Reset (reset low, async): state=IDLE, buf_vld=0, instr_vld_o=0, is_c_o=0, instr_o=0, mem_rd_o=0, mem_addr_o=0.
- Definitions: W = pc_i[ADDR_W+1:2], W1 = W+1 mod 2^ADDR_W (wraps to 0); hitW = buf_vld & buf_tag==W; half = pc_i[1] ? buf_word[31:16] : buf_word[15:0]; comp = half[1:0]!=2'b11.
- IDLE, req_i=1:
  - hitW & (pc_i[1]==0 | comp): respond combinationally, zero stall. instr_vld_o=1; instr_o = comp ? {16'h0,half} : buf_word; is_c_o=comp.
  - hitW & pc_i[1] & ~comp: mem_rd_o=1, mem_addr_o=W1, spill<=buf_word[31:16], go WAIT_HI.
  - ~hitW: mem_rd_o=1, mem_addr_o=W, go WAIT_LO.
- IDLE, req_i=0: no read, outputs invalid.
- WAIT_LO: buf_word<=mem_rdata_i, buf_tag<=W, buf_vld<=1; go IDLE. IDLE re-evaluates next cycle, which now hits. Aligned miss therefore costs 2 stall cycles.
- WAIT_HI: instr_vld_o=1, instr_o={mem_rdata_i[15:0], spill}, is_c_o=0; buf_word<=mem_rdata_i, buf_tag<=W1; go IDLE.
- Straddling miss: IDLE→WAIT_LO→IDLE→WAIT_HI, 3 stall cycles.
- Straddling hit: 1 stall cycle.
- req_i dropped in WAIT_*: fill still completes and the buffer updates; instr_vld_o stays 0.
- flush_i (any state) has priority over returning data. That data is discarded, buf unchanged, state→IDLE next cycle, no vld that cycle. A new pc_i is evaluated from the following cycle.
- pc_i changing while stall_o=1 without flush_i is illegal; there is no checker.
- Memory contents are static: the buffer is never invalidated except by reset, or by the optional feature below.

Optional Feature:
- Macro FETCH_FENCEI_EN.
- Defined: adds input fencei_i (1 bit). On fencei_i, buf_vld<=0 and any WAIT_* fill is discarded as for flush_i, so self-modified code is re-read.
- Undefined: no port; the buffer is invalidated only by reset.

Test Plan:
- Memory: word0=0x00A00093, word1=0x05130001, word2=0x45010010.
- Reset, req pc=0x0 → cycle0 mem_rd_o=1 addr 0; stall_o=1 for 2 cycles; cycle2 instr_o=0x00A00093, vld=1, is_c=0.
- pc=0x4 → aligned miss on word1, 2 stalls, instr_o=0x00000001, is_c=1. Then pc=0x6 → mem_rd addr 2, 1 stall, instr_o=0x00100513, is_c=0, buf_tag=2.
- Then pc=0xA → zero-stall hit, instr_o=0x00004501, is_c=1, no mem_rd_o.
- req pc=0x100 (read addr 0x40); next cycle flush_i=1 with pc=0x0 → rdata discarded, buf_tag≠0x40. Then read addr 0, instr_o=0x00A00093.
- Assert reset low during WAIT_HI → outputs 0, buf_vld=0 immediately. After release, the same pc re-issues the read of W.
- ADDR_W=4, word15 upper half 0x0513, word0 low half 0x0010, pc=0x3E → second read mem_addr_o=0, instr_o=0x00100513.
